store_buffer: RTL
=================

Name: store_buffer

Overview:
- Write-side counterpart to the core's load path: accepts sw stores from the datapath in one cycle, queues them, and drains them to DataMemory over a valid/ready write port.
- Loads that hit a pending store get the youngest buffered data forwarded combinationally.
- Sits between the Mips core (aluout/writedata/memwrite) and dmem.

Parameters:
DEPTH, 4, number of buffered stores (power of two, >= 2)
AW, 32, byte address width; entries hold word address AW-2 bits
DW, 32, data width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
st_valid  input  1  core presents a store this cycle
st_addr  input  AW  store byte address; bits [1:0] ignored
st_data  input  DW  store data
st_ready  output  1  buffer can accept a store this cycle
ld_addr  input  AW  current load byte address
ld_hit  output  1  a pending store matches ld_addr[AW-1:2]
ld_data  output  DW  data of youngest matching pending store; 0 when no hit
mem_we  output  1  head entry valid, write requested
mem_addr  output  AW  head entry word address, with [1:0]=2'b00
mem_wd  output  DW  head entry data
mem_ready  input  1  memory accepts the write this cycle
fence  input  1  block new stores until buffer drained
empty  output  1  no pending stores
count  output  $clog2(DEPTH)+1  number of pending stores

Behaviour:
Storage
- Circular FIFO of DEPTH entries {word_addr, data}, with wr_ptr, rd_ptr, count.
- Pointers wrap modulo DEPTH.

Reset (reset low, asynchronous)
- wr_ptr=rd_ptr=0, count=0.
- Outputs: empty=1, mem_we=0, mem_addr=0, mem_wd=0, ld_hit=0, ld_data=0, st_ready=1 (st_ready=0 if fence is high).
- Entry contents are don't-care and are never visible while count=0.
- Reset mid-drain discards all pending stores, including one presented with mem_ready=1 in the same cycle.

Enqueue
- st_ready = (count != DEPTH) && !fence, combinational.
- Accept when st_valid && st_ready: write entry at wr_ptr on the rising edge, then wr_ptr++.
- st_valid while st_ready=0 is ignored; the core must hold the request.

Dequeue
- mem_we = (count != 0); mem_addr and mem_wd are driven from the entry at rd_ptr (combinational from registered state).
- On a rising edge with mem_we && mem_ready: rd_ptr++.
- A store accepted into an empty buffer appears on mem_we the next cycle (latency 1 cycle; no bypass).

Count
- Enqueue only: count+1.
- Dequeue only: count-1.
- Both in the same cycle: count unchanged.
- When full, st_ready=0 even if a dequeue occurs that cycle; no enqueue on a full buffer.
- empty = (count==0).

Forwarding
- Compare ld_addr[AW-1:2] against every valid entry (those between rd_ptr and wr_ptr).
- The youngest match (closest to wr_ptr) wins.
- The head entry being dequeued this cycle still forwards.
- A store being enqueued in the same cycle does NOT forward; it is not yet registered.
- No match: ld_hit=0, ld_data=0.

Ordering
- Stores drain strictly in program order.
- Duplicate addresses are not coalesced; each store is written.

Fence
- While fence=1, st_ready=0.
- Draining continues normally.
- The core stalls until empty=1.

Test Plan:
- Reset: hold reset low, then release -> empty=1, count=0, mem_we=0, st_ready=1; assert reset low mid-operation with count=3 -> count=0 immediately, without waiting for a clock edge.
- Single store, mem_ready=1: store addr 12, data 999 -> next cycle mem_we=1, mem_addr=12, mem_wd=999; following cycle empty=1.
- Fill and stall: mem_ready=0, issue 5 stores (addr 0,4,8,12,16) -> first 4 accepted, count=4, st_ready=0, 5th held; set mem_ready=1 -> writes in order 0,4,8,12, then 16 accepted, with wrap-around exercised.
- Forwarding: mem_ready=0, store 8<-0x11 then 8<-0x22; ld_addr=8 -> ld_hit=1, ld_data=0x22; ld_addr=9 -> hit (word match); ld_addr=20 -> ld_hit=0, ld_data=0.
- Simultaneous enqueue/dequeue with count=2, mem_ready=1, st_valid=1 -> count stays 2, order preserved; repeat at full (count=4) -> no enqueue, count becomes 3.
- Fence: 3 pending stores, fence=1 with st_valid=1 -> st_ready=0; after 3 mem_ready cycles empty=1; drop fence -> store accepted.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between the core's sw path and data memory: in-order FIFO
// drain over a valid/ready write port, with youngest-match load forwarding.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wd,
    input  logic                     mem_ready,
    input  logic                     fence,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-3:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic enq, deq;

    // Byte offsets carry no information for word stores/loads.
    logic unused_lsbs;
    assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready = (count_q != CW'(DEPTH)) && !fence;
    assign mem_we   = (count_q != '0);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign enq      = st_valid && st_ready;
    assign deq      = mem_we && mem_ready;

    // Entries are not reset, so gate the head outputs while empty.
    assign mem_addr = mem_we ? {addr_q[rd_ptr_q], 2'b00} : '0;
    assign mem_wd   = mem_we ? data_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= st_addr[AW-1:2];
            data_q[wr_ptr_q] <= st_data;
        end
    end

    // Match vector indexed by age: slot k is the k-th oldest pending store.
    logic [DEPTH-1:0]          age_hit;
    logic [DEPTH-1:0][DW-1:0]  age_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_fwd
        logic [PW-1:0] idx;
        assign idx         = rd_ptr_q + PW'(k);
        assign age_hit[k]  = (CW'(k) < count_q) && (addr_q[idx] == ld_addr[AW-1:2]);
        assign age_data[k] = data_q[idx];
    end

    // Later ages overwrite earlier ones so the youngest match wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_hit[k]) begin
                ld_hit  = 1'b1;
                ld_data = age_data[k];
            end
        end
    end

endmodule
